// File: rtl/dm_mem_arbiter.sv
// ============================================================================
// Module  : dm_mem_arbiter
// Brief   : Round-robin arbiter sharing the DM memory port between two hosts.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    m0_req_i,
    input  logic                    m0_we_i,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_gnt_o,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,
    input  logic                    m1_req_i,
    input  logic                    m1_we_i,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_gnt_o,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,
    output logic                    device_req_o,
    output logic                    device_we_o,
    output logic [ADDR_WIDTH-1:0]   device_addr_o,
    output logic [DATA_WIDTH/8-1:0] device_be_o,
    output logic [DATA_WIDTH-1:0]   device_wdata_o,
    input  logic [DATA_WIDTH-1:0]   device_rdata_i
);

    typedef enum logic [0:0] {
        ARB_IDLE    = 1'b0,
        ARB_RD_WAIT = 1'b1
    } arb_state_t;

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_last_grant;
    logic       w_last_nxt;
    logic       r_owner;
    logic       w_owner_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_nxt;
            r_owner      <= w_owner_nxt;
        end
    end

    // Outputs are gated by rst_n so that everything reads 0 while reset is held,
    // including a read that was in flight when reset arrived.
    always_comb begin
        w_state_nxt    = r_state;
        w_last_nxt     = r_last_grant;
        w_owner_nxt    = r_owner;
        m0_gnt_o       = 1'b0;
        m1_gnt_o       = 1'b0;
        m0_rvalid_o    = 1'b0;
        m1_rvalid_o    = 1'b0;
        m0_rdata_o     = '0;
        m1_rdata_o     = '0;
        device_req_o   = 1'b0;
        device_we_o    = 1'b0;
        device_addr_o  = '0;
        device_be_o    = '0;
        device_wdata_o = '0;
        if (rst_n) begin
            case (r_state)
                ARB_IDLE: begin
                    // On contention the requester that was not granted last wins.
                    m0_gnt_o = m0_req_i & (~m1_req_i | r_last_grant);
                    m1_gnt_o = m1_req_i & (~m0_req_i | ~r_last_grant);
                    if (m0_gnt_o) begin
                        device_req_o   = 1'b1;
                        device_we_o    = m0_we_i;
                        device_addr_o  = m0_addr_i;
                        device_be_o    = m0_be_i;
                        device_wdata_o = m0_wdata_i;
                        w_last_nxt     = 1'b0;
                        if (!m0_we_i) begin
                            w_state_nxt = ARB_RD_WAIT;
                            w_owner_nxt = 1'b0;
                        end
                    end else if (m1_gnt_o) begin
                        device_req_o   = 1'b1;
                        device_we_o    = m1_we_i;
                        device_addr_o  = m1_addr_i;
                        device_be_o    = m1_be_i;
                        device_wdata_o = m1_wdata_i;
                        w_last_nxt     = 1'b1;
                        if (!m1_we_i) begin
                            w_state_nxt = ARB_RD_WAIT;
                            w_owner_nxt = 1'b1;
                        end
                    end
                end
                ARB_RD_WAIT: begin
                    w_state_nxt = ARB_IDLE;
                    if (r_owner) begin
                        m1_rvalid_o = 1'b1;
                        m1_rdata_o  = device_rdata_i;
                    end else begin
                        m0_rvalid_o = 1'b1;
                        m0_rdata_o  = device_rdata_i;
                    end
                end
                default: w_state_nxt = ARB_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dm_mem_arbiter.sv
// ============================================================================
// Module  : tb_dm_mem_arbiter
// Brief   : Self-checking bench: directed literal checks plus random traffic
//           compared every cycle against a transaction-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dm_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0;
    logic [1:0]  we = '0;
    logic [31:0] addr [2];
    logic [3:0]  be [2];
    logic [31:0] wdata [2];
    logic [31:0] devrdata = '0;

    logic        gnt0, gnt1, rv0, rv1, dreq, dwe;
    logic [31:0] rd0, rd1, daddr, dwd;
    logic [3:0]  dbe;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: which requester owes a read response (-1 none), last winner.
    int          mdl_pending = -1;
    int          mdl_last = 1;
    logic [1:0]  exp_gnt = '0;

    always #5 clk = ~clk;

    dm_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(req[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]), .m0_be_i(be[0]),
        .m0_wdata_i(wdata[0]), .m0_gnt_o(gnt0), .m0_rvalid_o(rv0), .m0_rdata_o(rd0),
        .m1_req_i(req[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]), .m1_be_i(be[1]),
        .m1_wdata_i(wdata[1]), .m1_gnt_o(gnt1), .m1_rvalid_o(rv1), .m1_rdata_o(rd1),
        .device_req_o(dreq), .device_we_o(dwe), .device_addr_o(daddr),
        .device_be_o(dbe), .device_wdata_o(dwd), .device_rdata_i(devrdata)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // Compare process: expected outputs from the current model state and inputs,
    // then advance the model to what the next rising edge produces.
    always @(negedge clk) begin
        int          win;
        logic [1:0]  e_gnt, e_rv;
        logic [31:0] e_rd [2];
        logic        e_req, e_we;
        logic [31:0] e_addr, e_wd;
        logic [3:0]  e_be;
        win = -1;
        e_gnt = '0; e_rv = '0; e_rd[0] = '0; e_rd[1] = '0;
        e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0; e_be = '0;
        if (rst_n) begin
            if (mdl_pending >= 0) begin
                e_rv[mdl_pending] = 1'b1;
                e_rd[mdl_pending] = devrdata;
            end else begin
                if (req == 2'b11)      win = (mdl_last == 1) ? 0 : 1;
                else if (req[0])       win = 0;
                else if (req[1])       win = 1;
                if (win >= 0) begin
                    e_gnt[win] = 1'b1;
                    e_req  = 1'b1;
                    e_we   = we[win];
                    e_addr = addr[win];
                    e_be   = be[win];
                    e_wd   = wdata[win];
                end
            end
        end
        chk("m0_gnt", 64'(gnt0), 64'(e_gnt[0]));
        chk("m1_gnt", 64'(gnt1), 64'(e_gnt[1]));
        chk("m0_rvalid", 64'(rv0), 64'(e_rv[0]));
        chk("m1_rvalid", 64'(rv1), 64'(e_rv[1]));
        chk("m0_rdata", 64'(rd0), 64'(e_rd[0]));
        chk("m1_rdata", 64'(rd1), 64'(e_rd[1]));
        chk("dev_req", 64'(dreq), 64'(e_req));
        chk("dev_we", 64'(dwe), 64'(e_we));
        chk("dev_addr", 64'(daddr), 64'(e_addr));
        chk("dev_be", 64'(dbe), 64'(e_be));
        chk("dev_wdata", 64'(dwd), 64'(e_wd));
        exp_gnt = e_gnt;
        if (!rst_n) begin
            mdl_pending = -1;
            mdl_last    = 1;
        end else if (mdl_pending >= 0) begin
            mdl_pending = -1;
        end else if (win >= 0) begin
            mdl_last = win;
            if (!we[win]) mdl_pending = win;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        addr[0] = '0; addr[1] = '0; be[0] = '0; be[1] = '0;
        wdata[0] = '0; wdata[1] = '0;
        cyc(); cyc();
        settle();
        chk("reset_gnt0", 64'(gnt0), 64'd0);
        chk("reset_dreq", 64'(dreq), 64'd0);
        chk("reset_dbe", 64'(dbe), 64'd0);

        // m0 read alone: grant now, data one cycle later
        cyc();
        rst_n = 1'b1; req = 2'b01; we = 2'b00; addr[0] = 32'h100; be[0] = 4'hF;
        devrdata = 32'h12345678;
        settle();
        chk("t1_gnt0", 64'(gnt0), 64'd1);
        chk("t1_gnt1", 64'(gnt1), 64'd0);
        chk("t1_addr", 64'(daddr), 64'h100);
        chk("t1_we", 64'(dwe), 64'd0);
        chk("t1_dreq", 64'(dreq), 64'd1);
        cyc();
        req = 2'b00; devrdata = 32'hCAFEF00D;
        settle();
        chk("t1_rv0", 64'(rv0), 64'd1);
        chk("t1_rd0", 64'(rd0), 64'hCAFEF00D);
        chk("t1_rv1", 64'(rv1), 64'd0);
        chk("t1_dreq_wait", 64'(dreq), 64'd0);

        // m0 granted last: m1 write wins, then m0 read, then no grant in wait
        cyc();
        req = 2'b11; we = 2'b10; addr[0] = 32'h200; addr[1] = 32'h300;
        wdata[1] = 32'h11111111; be[1] = 4'hF;
        settle();
        chk("t3_gnt1", 64'(gnt1), 64'd1);
        chk("t3_gnt0", 64'(gnt0), 64'd0);
        chk("t3_addr", 64'(daddr), 64'h300);
        chk("t3_we", 64'(dwe), 64'd1);
        cyc();
        req = 2'b01;
        settle();
        chk("t3_gnt0_rd", 64'(gnt0), 64'd1);
        chk("t3_addr_rd", 64'(daddr), 64'h200);
        cyc();
        req = 2'b10; devrdata = 32'h0BADCAFE;
        settle();
        chk("t3_nogrant_wait", 64'({gnt1, gnt0, dreq}), 64'd0);
        chk("t3_rv0", 64'(rv0), 64'd1);
        chk("t3_rd0", 64'(rd0), 64'h0BADCAFE);
        cyc();
        settle();
        chk("t3_gnt1_after", 64'(gnt1), 64'd1);
        cyc();
        req = 2'b00; rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;

        // both write continuously: alternate starting with m0
        req = 2'b11; we = 2'b11; wdata[0] = 32'hAAAA0000; wdata[1] = 32'hBBBB0000;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk("t2_gnt0", 64'(gnt0), 64'((i % 2) == 0));
            chk("t2_wdata", 64'(dwd), (i % 2 == 0) ? 64'hAAAA0000 : 64'hBBBB0000);
            cyc();
        end

        // m1 partial write
        req = 2'b10; we = 2'b10; be[1] = 4'b0011; wdata[1] = 32'hDEADBEEF;
        settle();
        chk("t4_be", 64'(dbe), 64'h3);
        chk("t4_we", 64'(dwe), 64'd1);
        chk("t4_wdata", 64'(dwd), 64'hDEADBEEF);
        cyc();
        req = 2'b00;
        settle();
        chk("t4_idle_be", 64'({dreq, dbe}), 64'd0);

        // reset during read wait drops the response
        cyc();
        req = 2'b10; we = 2'b00;
        settle();
        chk("t5_gnt1", 64'(gnt1), 64'd1);
        cyc();
        req = 2'b00; rst_n = 1'b0; devrdata = 32'h55555555;
        settle();
        chk("t5_rv1", 64'(rv1), 64'd0);
        chk("t5_rd1", 64'(rd1), 64'd0);
        chk("t5_outs", 64'({gnt0, gnt1, rv0, dreq}), 64'd0);
        cyc();
        rst_n = 1'b1; req = 2'b11; we = 2'b11;
        settle();
        chk("t5_gnt0_first", 64'({gnt1, gnt0}), 64'b01);

        // m1 requests only while m0 owns the port, then withdraws
        cyc();
        req = 2'b01; we = 2'b00; addr[0] = 32'h400;
        settle();
        chk("t6_gnt0_a", 64'(gnt0), 64'd1);
        cyc();
        req = 2'b11; addr[0] = 32'h404;
        settle();
        chk("t6_gnt1_a", 64'(gnt1), 64'd0);
        cyc();
        req = 2'b01;
        settle();
        chk("t6_gnt0_b", 64'(gnt0), 64'd1);
        chk("t6_gnt1_b", 64'(gnt1), 64'd0);
        cyc();
        req = 2'b00;
        settle();
        chk("t6_rv1", 64'(rv1), 64'd0);
        cyc();

        // random traffic with holds, withdrawals and occasional resets
        for (int c = 0; c < 3000; c++) begin
            devrdata = $urandom;
            rst_n = ($urandom_range(0, 199) != 0);
            for (int m = 0; m < 2; m++) begin
                if (req[m] && exp_gnt[m]) req[m] = 1'b0;
                else if (req[m] && $urandom_range(0, 15) == 0) req[m] = 1'b0;
                if (!req[m] && $urandom_range(0, 2) != 0) begin
                    req[m]   = 1'b1;
                    we[m]    = $urandom_range(0, 1) == 1;
                    addr[m]  = $urandom;
                    be[m]    = 4'($urandom);
                    wdata[m] = $urandom;
                end
            end
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
